// File: rtl/ps2_rx_frontend.sv
// ---------------------------------------------------------------------------
// ps2_rx_frontend
//   PS/2 keyboard receive front end. Synchronises the PS/2 clock and data
//   pins, deframes 11-bit frames (start 0, 8 data bits LSB first, odd parity,
//   stop 1) and turns good bytes into make/break key events.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   PS2_clk    PS/2 clock pin (asynchronous, idle high)
//   PS2_dat    PS/2 data pin (asynchronous, idle high)
//   rx_byte    last good frame data byte
//   rx_valid   1-cycle pulse when rx_byte is updated by a good frame
//   key_code   scan code of the last make/break event
//   key_make   1-cycle pulse: key pressed
//   key_break  1-cycle pulse: key released (byte following F0)
//   err        [0] parity error, [1] framing/timeout error; sticky until a
//              good frame
//   busy       high while a frame is in progress
// ---------------------------------------------------------------------------
module ps2_rx_frontend #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_clk,
    input  logic       PS2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_make,
    output logic       key_break,
    output logic [1:0] err,
    output logic       busy
);

    localparam int              TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic [7:0]             shreg;
    logic                   par;
    logic [2:0]             bit_cnt;
    logic [TW-1:0]          tcount;
    logic                   break_pending;

    logic clk_s;
    logic dat_s;
    logic fall;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // Equal-depth synchronisers keep the data sample aligned with the clock
    // edge that qualifies it. They reset to the idle-high level so leaving
    // reset can never manufacture a falling edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, regardless of statement order.
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_dat};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            par           <= 1'b0;
            bit_cnt       <= '0;
            tcount        <= '0;
            break_pending <= 1'b0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            key_code      <= '0;
            key_make      <= 1'b0;
            key_break     <= 1'b0;
            err           <= '0;
            busy          <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            key_make  <= 1'b0;
            key_break <= 1'b0;

            if (state != IDLE && tcount == TO_LAST) begin
                // Timeout beats any falling edge seen in the same cycle.
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
                tcount  <= '0;
                err[1]  <= 1'b1;
            end else begin
                if (fall || state == IDLE)
                    tcount <= '0;
                else
                    tcount <= tcount + 1'b1;

                if (fall) begin
                    case (state)
                        IDLE: begin
                            // A start sample of 1 is line noise: stay idle.
                            if (!dat_s) begin
                                state   <= DATA;
                                busy    <= 1'b1;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {dat_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par   <= dat_s;
                            state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!dat_s) begin
                                err[1] <= 1'b1;
                            end else if (!(^{shreg, par})) begin
                                err[0] <= 1'b1;
                            end else begin
                                rx_byte  <= shreg;
                                rx_valid <= 1'b1;
                                err      <= '0;
                                if (shreg == 8'hF0) begin
                                    break_pending <= 1'b1;
                                end else if (shreg != 8'hE0) begin
                                    key_code      <= shreg;
                                    key_make      <= ~break_pending;
                                    key_break     <= break_pending;
                                    break_pending <= 1'b0;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
`timescale 1ns/1ps
module tb_ps2_rx_frontend;

    localparam int TO   = 200;
    localparam int SYNC = 2;
    localparam int HALF = 8;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PS2_clk = 1'b1;
    logic       PS2_dat = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_make;
    logic       key_break;
    logic [1:0] err;
    logic       busy;

    ps2_rx_frontend #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .PS2_clk  (PS2_clk),
        .PS2_dat  (PS2_dat),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .key_code (key_code),
        .key_make (key_make),
        .key_break(key_break),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int  errors   = 0;
    int  n_checks = 0;
    int  n_valid  = 0;
    int  n_make   = 0;
    int  n_break  = 0;
    time t_fall   = 0;
    time t_valid  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            t_valid = $time;
        end
        if (key_make)  n_make++;
        if (key_break) n_break++;
        if (key_make || key_break)
            check("key_pulse_shape", {30'd0, key_make & key_break, ~rx_valid}, 32'd0);
    end

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Drives the first n bits of a frame; data changes while PS2_clk is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_dat = f[i];
            repeat (HALF) @(negedge clk);
            PS2_clk = 1'b0;
            t_fall  = $time;
            repeat (HALF) @(negedge clk);
            PS2_clk = 1'b1;
        end
        PS2_dat = 1'b1;
    endtask

    task automatic gap();
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        int         d_valid;
        int         d_make;
        int         d_break;
        logic [7:0] exp_rx;
        logic [7:0] exp_code;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[10];
    int   v0, m0, b0;

    initial begin
        //            data   badp  stop  val make brk  rx     code   err
        vecs[0] = '{8'h25, 1'b0, 1'b1, 1, 1, 0, 8'h25, 8'h25, 2'b00};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 8'hF0, 8'h25, 2'b00};
        vecs[2] = '{8'h25, 1'b0, 1'b1, 1, 0, 1, 8'h25, 8'h25, 2'b00};
        vecs[3] = '{8'h45, 1'b1, 1'b1, 0, 0, 0, 8'h25, 8'h25, 2'b01};
        vecs[4] = '{8'h45, 1'b0, 1'b1, 1, 1, 0, 8'h45, 8'h45, 2'b00};
        vecs[5] = '{8'h1C, 1'b0, 1'b0, 0, 0, 0, 8'h45, 8'h45, 2'b10};
        vecs[6] = '{8'h5A, 1'b0, 1'b1, 1, 1, 0, 8'h5A, 8'h5A, 2'b00};
        vecs[7] = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 8'hE0, 8'h5A, 2'b00};
        vecs[8] = '{8'hF0, 1'b1, 1'b1, 0, 0, 0, 8'hE0, 8'h5A, 2'b01};
        vecs[9] = '{8'h1C, 1'b0, 1'b1, 1, 1, 0, 8'h1C, 8'h1C, 2'b00};

        repeat (3) @(negedge clk);
        check("reset_outputs", {14'd0, rx_byte, key_code, err}, 32'd0);
        check("reset_pulses", {28'd0, rx_valid, key_make, key_break, busy}, 32'd0);
        rst = 1'b0;
        gap();

        // A lone falling edge with data 1 is not a start bit.
        send_bits(11'h7FF, 1);
        gap();
        check("idle_noise_busy", {31'd0, busy}, 32'd0);
        check("idle_noise_err", {30'd0, err}, 32'd0);

        foreach (vecs[i]) begin
            v0 = n_valid; m0 = n_make; b0 = n_break;
            send_bits(frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop), 11);
            gap();
            check($sformatf("v%0d_valid", i), 32'(n_valid - v0), 32'(vecs[i].d_valid));
            check($sformatf("v%0d_make", i),  32'(n_make - m0),  32'(vecs[i].d_make));
            check($sformatf("v%0d_break", i), 32'(n_break - b0), 32'(vecs[i].d_break));
            check($sformatf("v%0d_rx", i),    32'(rx_byte),      32'(vecs[i].exp_rx));
            check($sformatf("v%0d_code", i),  32'(key_code),     32'(vecs[i].exp_code));
            check($sformatf("v%0d_err", i),   32'(err),          32'(vecs[i].exp_err));
            check($sformatf("v%0d_busy", i),  32'(busy),         32'd0);
            if (vecs[i].d_valid != 0)
                check($sformatf("v%0d_latency_ok", i),
                      32'((t_valid >= t_fall) && (t_valid - t_fall <= (SYNC + 2) * 10)), 32'd1);
        end

        // Timeout: start bit plus 4 data bits, then silence.
        v0 = n_valid;
        send_bits(frame(8'h33, 1'b0, 1'b1), 5);
        check("to_busy_mid", 32'(busy), 32'd1);
        repeat (TO + 5) @(negedge clk);
        check("to_err", 32'(err), 32'd2);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_valid", 32'(n_valid - v0), 32'd0);
        m0 = n_make;
        send_bits(frame(8'h16, 1'b0, 1'b1), 11);
        gap();
        check("to_next_make", 32'(n_make - m0), 32'd1);
        check("to_next_code", 32'(key_code), 32'h16);
        check("to_next_err", 32'(err), 32'd0);

        // Reset mid-frame after an F0 must clear break_pending.
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11);
        gap();
        send_bits(frame(8'h24, 1'b0, 1'b1), 4);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", {14'd0, rx_byte, key_code, err}, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        gap();
        m0 = n_make; b0 = n_break;
        send_bits(frame(8'h24, 1'b0, 1'b1), 11);
        gap();
        check("rst_make", 32'(n_make - m0), 32'd1);
        check("rst_no_break", 32'(n_break - b0), 32'd0);
        check("rst_code", 32'(key_code), 32'h24);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
